// File: rtl/um_ppm_pkg.sv
// Shared constants, timeline record and helpers for the PPM modulator/demodulator.
// PPM_GUARD_SLOT_EN adds a 17th always-low guard slot to every frame.
package um_ppm_pkg;

   localparam int NUM_SLOTS   = 16;
   localparam int SLOT_W      = 4;
   localparam int PRESCALE_W  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int SLOT_CNT_W  = SLOT_W + 1;

   localparam logic [SLOT_CNT_W-1:0] GUARD_SLOT = 5'd16;
`ifdef PPM_GUARD_SLOT_EN
   localparam logic [SLOT_CNT_W-1:0] LAST_SLOT = GUARD_SLOT;
`else
   localparam logic [SLOT_CNT_W-1:0] LAST_SLOT = 5'(NUM_SLOTS - 1);
`endif

   // One cycle of frame position as seen by the TX output registers.
   typedef struct packed {
      logic                  vld;
      logic [SLOT_CNT_W-1:0] slot;
      logic [PRESCALE_W-1:0] pre;
      logic [PRESCALE_W-1:0] len;
   } timeline_t;

   function automatic logic slot_last(input timeline_t t);
      return t.vld && (t.pre == t.len);
   endfunction

endpackage

// File: rtl/um_ppm_rx.sv
// PPM demodulator: synchronizer, delayed timeline, per-slot sampler and frame verdict.
// PPM_GUARD_SLOT_EN: a high sample in the guard slot spoils the frame.
module um_ppm_rx
   import um_ppm_pkg::*;
#(
   parameter int SYNC_N = SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              rx_in,
   input  timeline_t         tl_in,
   output logic              rx_vld,
   output logic              rx_err,
   output logic [SLOT_W-1:0] rx_sym
);

   logic [SYNC_N-1:0]     sync_q, sync_d;
   timeline_t [SYNC_N-1:0] tl_pipe_q, tl_pipe_d;

   logic              smp_vld_q, smp_vld_d;
   logic              smp_bit_q, smp_bit_d;
   logic              smp_end_q, smp_end_d;
   logic [SLOT_W-1:0] smp_slot_q, smp_slot_d;
`ifdef PPM_GUARD_SLOT_EN
   logic              smp_guard_q, smp_guard_d;
   logic              guard_hit_q, guard_hit_d;
   logic              guard_nx;
`endif

   logic [1:0]        cnt_q, cnt_d;
   logic [SLOT_W-1:0] cap_q, cap_d;
   logic              vld_q, vld_d;
   logic              err_q, err_d;
   logic [SLOT_W-1:0] sym_q, sym_d;

   timeline_t         tl_dly;
   logic [1:0]        cnt_nx;
   logic [SLOT_W-1:0] cap_nx;
   logic              good;

   always_comb begin
      sync_d     = sync_q;
      tl_pipe_d  = tl_pipe_q;
      smp_vld_d  = smp_vld_q;
      smp_bit_d  = smp_bit_q;
      smp_end_d  = smp_end_q;
      smp_slot_d = smp_slot_q;
`ifdef PPM_GUARD_SLOT_EN
      smp_guard_d = smp_guard_q;
      guard_hit_d = guard_hit_q;
      guard_nx    = guard_hit_q;
`endif
      cnt_d  = cnt_q;
      cap_d  = cap_q;
      vld_d  = vld_q;
      err_d  = err_q;
      sym_d  = sym_q;
      tl_dly = tl_pipe_q[SYNC_N-1];
      cnt_nx = cnt_q;
      cap_nx = cap_q;
      good   = 1'b0;

      if (ena) begin
         sync_d[0]    = rx_in;
         tl_pipe_d[0] = tl_in;
         for (int i = 1; i < SYNC_N; i++) begin
            sync_d[i]    = sync_q[i-1];
            tl_pipe_d[i] = tl_pipe_q[i-1];
         end

         // Synchronized bit and delayed timeline line up here; sample on the slot's last cycle.
         smp_vld_d  = slot_last(tl_dly);
         smp_bit_d  = sync_q[SYNC_N-1];
         smp_slot_d = tl_dly.slot[SLOT_W-1:0];
         smp_end_d  = slot_last(tl_dly) && (tl_dly.slot == LAST_SLOT);
`ifdef PPM_GUARD_SLOT_EN
         smp_guard_d = (tl_dly.slot == GUARD_SLOT);
`endif

         vld_d = 1'b0;
         if (smp_vld_q && smp_bit_q) begin
`ifdef PPM_GUARD_SLOT_EN
            if (smp_guard_q) guard_nx = 1'b1;
            else begin
`else
            begin
`endif
               cnt_nx = (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
               cap_nx = smp_slot_q;
            end
         end

`ifdef PPM_GUARD_SLOT_EN
         good = (cnt_nx == 2'd1) && !guard_nx;
`else
         good = (cnt_nx == 2'd1);
`endif

         if (smp_end_q) begin
            cnt_d = 2'd0;
            cap_d = cap_nx;
`ifdef PPM_GUARD_SLOT_EN
            guard_hit_d = 1'b0;
`endif
            if (good) begin
               sym_d = cap_nx;
               vld_d = 1'b1;
               err_d = 1'b0;
            end else begin
               err_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_nx;
            cap_d = cap_nx;
`ifdef PPM_GUARD_SLOT_EN
            guard_hit_d = guard_nx;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= '0;
         tl_pipe_q   <= '0;
         smp_vld_q   <= 1'b0;
         smp_bit_q   <= 1'b0;
         smp_end_q   <= 1'b0;
         smp_slot_q  <= '0;
`ifdef PPM_GUARD_SLOT_EN
         smp_guard_q <= 1'b0;
         guard_hit_q <= 1'b0;
`endif
         cnt_q       <= '0;
         cap_q       <= '0;
         vld_q       <= 1'b0;
         err_q       <= 1'b0;
         sym_q       <= '0;
      end else begin
         sync_q      <= sync_d;
         tl_pipe_q   <= tl_pipe_d;
         smp_vld_q   <= smp_vld_d;
         smp_bit_q   <= smp_bit_d;
         smp_end_q   <= smp_end_d;
         smp_slot_q  <= smp_slot_d;
`ifdef PPM_GUARD_SLOT_EN
         smp_guard_q <= smp_guard_d;
         guard_hit_q <= guard_hit_d;
`endif
         cnt_q       <= cnt_d;
         cap_q       <= cap_d;
         vld_q       <= vld_d;
         err_q       <= err_d;
         sym_q       <= sym_d;
      end
   end

   assign rx_vld = vld_q;
   assign rx_err = err_q;
   assign rx_sym = sym_q;

endmodule

// File: rtl/um_ppm.sv
// Tiny Tapeout PPM transmitter with matching receiver (loopback or external pin).
// PPM_GUARD_SLOT_EN: 17-slot frames, slot 16 is an always-low guard slot shown as index 4'hF.
module um_ppm
   import um_ppm_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [PRESCALE_W-1:0] pre_q, pre_d;
   logic [SLOT_CNT_W-1:0] slot_q, slot_d;
   logic [SLOT_W-1:0]     sym_q, sym_d;
   logic [PRESCALE_W-1:0] len_q, len_d;
   logic                  pulse_q, pulse_d;
   logic                  strobe_q, strobe_d;
   logic [SLOT_W-1:0]     slot_out_q, slot_out_d;
   timeline_t             tl_q, tl_d;

   logic                  frame_start;
   logic [SLOT_W-1:0]     cur_sym;
   logic [PRESCALE_W-1:0] cur_len;

   logic                  rx_mux;
   logic                  rx_vld;
   logic                  rx_err;
   logic [SLOT_W-1:0]     rx_sym;
   logic                  unused_uio;

   always_comb begin
      // Symbol and slot length are taken from the pins only on the first cycle of a frame.
      frame_start = (slot_q == '0) && (pre_q == '0);
      cur_sym     = frame_start ? ui_in[3:0] : sym_q;
      cur_len     = frame_start ? ui_in[7:4] : len_q;

      pre_d      = pre_q;
      slot_d     = slot_q;
      sym_d      = sym_q;
      len_d      = len_q;
      pulse_d    = pulse_q;
      strobe_d   = strobe_q;
      slot_out_d = slot_out_q;
      tl_d       = tl_q;

      if (ena) begin
         sym_d = cur_sym;
         len_d = cur_len;
         if (pre_q == cur_len) begin
            pre_d  = '0;
            slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 5'd1;
         end else begin
            pre_d  = pre_q + 4'd1;
         end
         strobe_d = frame_start;
         pulse_d  = (slot_q == {1'b0, cur_sym});
`ifdef PPM_GUARD_SLOT_EN
         slot_out_d = (slot_q == GUARD_SLOT) ? 4'hF : slot_q[SLOT_W-1:0];
`else
         slot_out_d = slot_q[SLOT_W-1:0];
`endif
         tl_d.vld  = 1'b1;
         tl_d.slot = slot_q;
         tl_d.pre  = pre_q;
         tl_d.len  = cur_len;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q      <= '0;
         slot_q     <= '0;
         sym_q      <= '0;
         len_q      <= '0;
         pulse_q    <= 1'b0;
         strobe_q   <= 1'b0;
         slot_out_q <= '0;
         tl_q       <= '0;
      end else begin
         pre_q      <= pre_d;
         slot_q     <= slot_d;
         sym_q      <= sym_d;
         len_q      <= len_d;
         pulse_q    <= pulse_d;
         strobe_q   <= strobe_d;
         slot_out_q <= slot_out_d;
         tl_q       <= tl_d;
      end
   end

   assign rx_mux = uio_in[1] ? pulse_q : uio_in[0];

   um_ppm_rx #(
      .SYNC_N (SYNC_STAGES)
   ) u_rx (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .rx_in  (rx_mux),
      .tl_in  (tl_q),
      .rx_vld (rx_vld),
      .rx_err (rx_err),
      .rx_sym (rx_sym)
   );

   assign uo_out     = {rx_sym, rx_err, rx_vld, strobe_q, pulse_q};
   assign uio_out    = {slot_out_q, 4'h0};
   assign uio_oe     = 8'hF0;
   assign unused_uio = ^uio_in[7:2];

endmodule

// File: tb/tb_um_ppm.sv
// Directed bench for um_ppm: reset, loopback decode, merged pulse, external errors, mid-frame change, ena freeze.
module tb_um_ppm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic [7:0] uio_in = 8'h00;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int         n_chk = 0;
   int         n_err = 0;
   logic [3:0] dec_q[$];
   logic [2:0] ctl_exp;

   always #5 clk = ~clk;

   um_ppm dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_strobe();
      bit found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (uo_out[1]) found = 1'b1;
      end
      chk("strobe_seen", {31'd0, found}, 32'd1);
   endtask

   initial begin
      // Reset: outputs clear even while clocks run with ena high.
      ui_in  = 8'h05;
      uio_in = 8'h02;
      ena    = 1'b1;
      #3;
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_uio", uio_out, 8'h00);
      chk("rst_oe", uio_oe, 8'hF0);
      step();
      step();
      chk("rst_uo_clk", uo_out, 8'h00);

      // Released but disabled: nothing starts.
      ena   = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("idle_uo", uo_out, 8'h00);
         chk("idle_uio", uio_out, 8'h00);
      end

      // Loopback, sym 5, L 1: strobe on the first enabled edge.
      ena = 1'b1;
      step();
      chk("lb_first", uo_out, 8'h02);
      chk("lb_first_slot", uio_out, 8'h00);
      for (int k = 1; k <= 20; k++) begin
         step();
         ctl_exp = {k == 19, (k % 16) == 0, (k % 16) == 5};
         chk("lb_ctl", {29'd0, uo_out[2:0]}, {29'd0, ctl_exp});
         chk("lb_slot", uio_out[7:4], k % 16);
         if (k == 19) begin
            chk("lb_sym", uo_out[7:4], 4'd5);
            chk("lb_err", uo_out[3], 1'b0);
         end
      end

      // External RX: pulses in slots 2 and 9, then a single pulse in slot 3.
      ui_in = 8'h00;
      wait_strobe();
      uio_in = 8'h00;
      for (int k = 1; k <= 35; k++) begin
         step();
         uio_in[0] = (k < 16 && (k == 2 || k == 9)) || (k >= 16 && k < 32 && (k % 16) == 3);
         if (k == 18) chk("ext_err_before", uo_out[3], 1'b0);
         if (k == 19) begin
            chk("ext_bad_vld", uo_out[2], 1'b0);
            chk("ext_bad_err", uo_out[3], 1'b1);
            chk("ext_bad_sym", uo_out[7:4], 4'd5);
         end
         if (k == 34) chk("ext_err_sticky", uo_out[3], 1'b1);
         if (k == 35) begin
            chk("ext_good_vld", uo_out[2], 1'b1);
            chk("ext_good_sym", uo_out[7:4], 4'd3);
            chk("ext_good_err", uo_out[3], 1'b0);
         end
      end

      // L 4: sym 15 then sym 0 gives one 8-cycle pulse across the frame boundary.
      uio_in = 8'h02;
      ui_in  = 8'h3F;
      wait_strobe();
      ui_in = 8'h30;
      for (int k = 1; k <= 135; k++) begin
         step();
         if (k >= 56 && k <= 70) chk("merge_pulse", uo_out[0], (k >= 60 && k <= 67));
         if (uo_out[2] && k > 8) dec_q.push_back(uo_out[7:4]);
         if (k == 135) chk("merge_err", uo_out[3], 1'b0);
      end
      chk("merge_ndec", dec_q.size(), 2);
      chk("merge_dec0", (dec_q.size() > 0) ? {28'd0, dec_q[0]} : 32'hFFFF, 32'd15);
      chk("merge_dec1", (dec_q.size() > 1) ? {28'd0, dec_q[1]} : 32'hFFFF, 32'd0);

      // Mid-frame change: L 2 / sym 6 frame keeps its settings, next frame L 4 / sym 10.
      ui_in = 8'h16;
      wait_strobe();
      for (int k = 1; k <= 137; k++) begin
         step();
         if (k == 14) begin
            chk("mf_slot7", uio_out[7:4], 4'd7);
            ui_in = 8'h3A;
         end
         if (k <= 100) begin
            ctl_exp = {k == 3 || k == 35 || k == 99, k == 32 || k == 96,
                       (k >= 12 && k <= 13) || (k >= 72 && k <= 75)};
            chk("mf_ctl", {29'd0, uo_out[2:0]}, {29'd0, ctl_exp});
         end
         if (k == 35) chk("mf_sym_old", uo_out[7:4], 4'd6);
         if (k == 72) chk("mf_slot10", uio_out[7:4], 4'd10);
         if (k == 99) chk("mf_sym_new", uo_out[7:4], 4'd10);
      end

      // ena low for 10 cycles during the second cycle of a 4-cycle pulse.
      chk("frz_pre", uo_out, 8'hA1);
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("frz_uo", uo_out, 8'hA1);
         chk("frz_uio", uio_out, 8'hA0);
      end
      ena = 1'b1;
      step();
      chk("resume_p3", uo_out[0], 1'b1);
      step();
      chk("resume_p4", uo_out[0], 1'b1);
      step();
      chk("resume_end", uo_out[0], 1'b0);
      chk("resume_slot", uio_out, 8'hB0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
